// File: rtl/seg7_capture.sv
// seg7_capture: recovers 4-digit frames from a multiplexed, active-low
// 7-segment display bus and presents them with a valid/ready handshake.
//
// Ports:
//   clk, rst        single rising-edge clock, synchronous active-high reset
//   an[3:0]         active-low digit enables (exactly one low = valid sample)
//   seg[6:0]        active-low segments, seg[6]=a ... seg[0]=g
//   out_ready       consumer accepts the presented frame
//   digits[15:0]    recovered frame, slot i at digits[4i+3:4i]
//   err_mask[3:0]   slot i carried an unrecognised segment pattern
//   frame_valid     digits/err_mask hold a complete frame
//   frame_err       OR of err_mask, registered together with frame_valid
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        out_ready,
    output logic [15:0] digits,
    output logic [3:0]  err_mask,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned SLOTS   = 4;
    localparam int unsigned DIGIT_W = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             prev_an_q, prev_an_d;
    logic [6:0]             prev_seg_q, prev_seg_d;
    logic [15:0]            shadow_q, shadow_d;
    logic [SLOTS-1:0]       shadow_err_q, shadow_err_d;
    logic [SLOTS-1:0]       seen_q, seen_d;
    logic [15:0]            digits_q, digits_d;
    logic [SLOTS-1:0]       err_mask_q, err_mask_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   frame_err_q, frame_err_d;

    logic [DIGIT_W-1:0]     dec_val;
    logic                   dec_err;
    logic                   sample_valid;
    logic [1:0]             slot;
    logic                   same_sample;
    logic                   capture;

    // Segment pattern to BCD value; anything unknown (blank included) is an error.
    always_comb begin
        dec_err = 1'b0;
        case (seg)
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0000100: dec_val = 4'd9;
            default: begin
                dec_val = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    // Only a one-hot-low enable is a sample; all-high or multiple lows are idle.
    always_comb begin
        sample_valid = 1'b1;
        slot         = 2'd0;
        case (an)
            4'b1110: slot = 2'd0;
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: sample_valid = 1'b0;
        endcase
    end

    // A zero count means the previous sample was idle (or reset), so no match.
    assign same_sample = (cnt_q != '0) && (an == prev_an_q) && (seg == prev_seg_q);

    // Fires once per dwell: only on the step from STABLE_CYCLES-1 to STABLE_CYCLES.
    assign capture = sample_valid && same_sample
                     && (cnt_q == CNT_W'(STABLE_CYCLES - 1));

    // Next-state and datapath.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        prev_an_d     = an;
        prev_seg_d    = seg;
        shadow_d      = shadow_q;
        shadow_err_d  = shadow_err_q;
        seen_d        = seen_q;
        digits_d      = digits_q;
        err_mask_d    = err_mask_q;
        frame_valid_d = frame_valid_q;
        frame_err_d   = frame_err_q;

        // Stability counter, saturating at STABLE_CYCLES.
        if (!sample_valid) begin
            cnt_d = '0;
        end else if (same_sample) begin
            if (cnt_q < CNT_W'(STABLE_CYCLES)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = CNT_W'(1);
        end

        // Latest capture into a slot wins.
        for (int i = 0; i < int'(SLOTS); i++) begin
            if (capture && (slot == 2'(i))) begin
                shadow_d[DIGIT_W*i +: DIGIT_W] = dec_val;
                shadow_err_d[i]                = dec_err;
            end
        end

        case (state_q)
            COLLECT: begin
                if (seen_q == 4'b1111) begin
                    // Copy uses pre-edge shadow; a same-edge capture seeds the next frame.
                    digits_d      = shadow_q;
                    err_mask_d    = shadow_err_q;
                    frame_err_d   = |shadow_err_q;
                    frame_valid_d = 1'b1;
                    state_d       = PRESENT;
                    seen_d        = '0;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    frame_valid_d = 1'b0;
                    state_d       = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        if (capture) begin
            seen_d[slot] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= COLLECT;
            cnt_q         <= '0;
            prev_an_q     <= '1;
            prev_seg_q    <= '1;
            shadow_q      <= '0;
            shadow_err_q  <= '0;
            seen_q        <= '0;
            digits_q      <= '0;
            err_mask_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prev_an_q     <= prev_an_d;
            prev_seg_q    <= prev_seg_d;
            shadow_q      <= shadow_d;
            shadow_err_q  <= shadow_err_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            err_mask_q    <= err_mask_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign digits      = digits_q;
    assign err_mask    = err_mask_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: frame capture, error slots, idle and
// multi-enable rejection, frozen presentation and reset behaviour.
module tb_seg7_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        out_ready;
    logic [15:0] digits;
    logic [3:0]  err_mask;
    logic        frame_valid;
    logic        frame_err;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] S0 = 4'b1110;
    localparam logic [3:0] S1 = 4'b1101;
    localparam logic [3:0] S2 = 4'b1011;
    localparam logic [3:0] S3 = 4'b0111;
    localparam logic [3:0] IDLE = 4'b1111;
    localparam logic [6:0] BLANK = 7'b1111111;

    seg7_capture #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .an          (an),
        .seg         (seg),
        .out_ready   (out_ready),
        .digits      (digits),
        .err_mask    (err_mask),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] code(input int d);
        case (d)
            0: code = 7'b0000001;
            1: code = 7'b1001111;
            2: code = 7'b0010010;
            3: code = 7'b0000110;
            4: code = 7'b1001100;
            5: code = 7'b0100100;
            6: code = 7'b0100000;
            7: code = 7'b0001111;
            8: code = 7'b0000000;
            9: code = 7'b0000100;
            default: code = 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are set, then one rising edge samples them; outputs read 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) step();
    endtask

    task automatic scan(input int d0, input int d1, input int d2, input int d3);
        hold(S0, code(d0), 4);
        hold(S1, code(d1), 4);
        hold(S2, code(d2), 4);
        hold(S3, code(d3), 4);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        hold(IDLE, BLANK, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; an = IDLE; seg = BLANK; out_ready = 1'b0;
        step(); step();
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_err_mask", 32'(err_mask), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        rst = 1'b0;

        // Basic frame 4321 and one-cycle latency after the last capture.
        scan(1, 2, 3, 4);
        chk("f1_fv_at_capture", 32'(frame_valid), 32'h0);
        hold(IDLE, BLANK, 1);
        chk("f1_fv", 32'(frame_valid), 32'h1);
        chk("f1_digits", 32'(digits), 32'h4321);
        chk("f1_err_mask", 32'(err_mask), 32'h0);
        chk("f1_ferr", 32'(frame_err), 32'h0);
        hold(IDLE, BLANK, 5);
        chk("f1_fv_hold", 32'(frame_valid), 32'h1);
        handshake();
        chk("f1_fv_drop", 32'(frame_valid), 32'h0);

        // Short dwell on slot 2, then multi-enable sample: no capture, no frame.
        hold(S0, code(5), 4);
        hold(S1, code(6), 4);
        hold(S3, code(8), 4);
        hold(S2, code(9), 3);
        hold(IDLE, BLANK, 2);
        chk("short_dwell_no_fv", 32'(frame_valid), 32'h0);
        out_ready = 1'b1;
        hold(4'b0011, code(0), 10);
        out_ready = 1'b0;
        chk("multi_an_no_fv", 32'(frame_valid), 32'h0);
        hold(S2, code(7), 4);
        hold(IDLE, BLANK, 1);
        chk("f2_fv", 32'(frame_valid), 32'h1);
        chk("f2_digits", 32'(digits), 32'h8765);
        handshake();

        // Blank slot 1 and a slot 0 re-capture where the latest value wins.
        hold(S0, code(5), 4);
        hold(S0, code(0), 4);
        hold(S1, BLANK, 4);
        hold(S2, code(2), 4);
        hold(S3, code(9), 4);
        hold(IDLE, BLANK, 1);
        chk("f3_fv", 32'(frame_valid), 32'h1);
        chk("f3_digits", 32'(digits), 32'h92F0);
        chk("f3_err_mask", 32'(err_mask), 32'h2);
        chk("f3_ferr", 32'(frame_err), 32'h1);
        handshake();

        // Frozen output while the next frame is scanned during PRESENT.
        scan(6, 7, 8, 9);
        hold(IDLE, BLANK, 1);
        chk("f4_digits", 32'(digits), 32'h9876);
        scan(5, 0, 5, 0);
        chk("f4_frozen_mid", 32'(digits), 32'h9876);
        hold(IDLE, BLANK, 34);
        chk("f4_frozen_end", 32'(digits), 32'h9876);
        chk("f4_fv_held", 32'(frame_valid), 32'h1);
        handshake();
        chk("f4_gap", 32'(frame_valid), 32'h0);
        hold(IDLE, BLANK, 1);
        chk("f5_fv", 32'(frame_valid), 32'h1);
        chk("f5_digits", 32'(digits), 32'h0505);
        handshake();

        // Reset while presenting; post-reset dwell restarts at sample 1.
        scan(1, 1, 1, 1);
        hold(IDLE, BLANK, 1);
        chk("f6_fv", 32'(frame_valid), 32'h1);
        rst = 1'b1;
        hold(S0, code(3), 1);
        rst = 1'b0;
        chk("rst2_fv", 32'(frame_valid), 32'h0);
        chk("rst2_digits", 32'(digits), 32'h0);
        hold(S0, code(3), 3);
        hold(S1, code(4), 4);
        hold(S2, code(5), 4);
        hold(S3, code(6), 4);
        hold(IDLE, BLANK, 2);
        chk("rst2_partial_no_fv", 32'(frame_valid), 32'h0);
        hold(S0, code(3), 4);
        hold(IDLE, BLANK, 1);
        chk("f7_fv", 32'(frame_valid), 32'h1);
        chk("f7_digits", 32'(digits), 32'h6543);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
